fir_mac_ctrl: RTL and testbench

Sequencing controller for the FIR multiply-accumulate datapath. It accepts 3-bit signed samples over a valid/ready handshake and shifts them into a 10-tap delay line. It holds the 10×16-bit coefficient bank, steps the MAC enables through the mul→add→acc pipeline, captures the 16-bit MAC result, and presents it on a valid/ready output. It sits between the sample source and the MAC datapath, and drives that datapath's iDelay, iCoeff, iEnMul, iEnAdd and iEnAcc inputs.

---
 rtl/fir_pkg.sv | 22 ++
 rtl/fir_delay_line.sv | 22 ++
 rtl/fir_mac_ctrl.sv | 81 ++++++++
 tb/tb_fir_mac_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// fir_pkg: shared sizes, FSM encoding and tap slice helpers for the FIR MAC controller
package fir_pkg;
  localparam int TAPS   = 10;
  localparam int DWIDTH = 3;
  localparam int CWIDTH = 16;
  localparam int DW_ALL = TAPS * DWIDTH;
  localparam int CW_ALL = TAPS * CWIDTH;
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MUL  = 3'd1,
    ADD  = 3'd2,
    ACC  = 3'd3,
    OUT  = 3'd4
  } state_t;
  // tap 0 occupies the most significant slice of each bus
  function automatic int dly_hi(input int j);
    return DW_ALL - 1 - DWIDTH * j;
  endfunction
  function automatic int coef_hi(input int j);
    return CW_ALL - 1 - CWIDTH * j;
  endfunction
endpackage

// File: rtl/fir_delay_line.sv
// fir_delay_line: sample shift register, newest sample enters at tap 0
module fir_delay_line
  import fir_pkg::*;
(
  input  logic              iClk,
  input  logic              iRsn,
  input  logic              iShift,
  input  logic              iFlush,
  input  logic [DWIDTH-1:0] iData,
  output logic [DW_ALL-1:0] oDelay
);
  logic [DW_ALL-1:0] dly_q, dly_d, base;
  // flush clears first so a same-edge shift lands on an empty line
  always_comb begin
    base  = iFlush ? '0 : dly_q;
    dly_d = iShift ? {iData, base[DW_ALL-1:DWIDTH]} : base;
  end
  always_ff @(posedge iClk or negedge iRsn)
    if (!iRsn) dly_q <= '0;
    else       dly_q <= dly_d;
  assign oDelay = dly_q;
endmodule

// File: rtl/fir_mac_ctrl.sv
// fir_mac_ctrl: sequences samples and coefficients through the external MAC pipeline
module fir_mac_ctrl
  import fir_pkg::*;
(
  input  logic              iClk,
  input  logic              iRsn,
  input  logic              iEnable,
  input  logic              iInValid,
  input  logic [DWIDTH-1:0] iInData,
  output logic              oInReady,
  input  logic              iFlush,
  input  logic              iCoeffWe,
  input  logic [3:0]        iCoeffAddr,
  input  logic [CWIDTH-1:0] iCoeffData,
  output logic              oCoeffErr,
  output logic [DW_ALL-1:0] oDelay,
  output logic [CW_ALL-1:0] oCoeff,
  output logic              oEnMul,
  output logic              oEnAdd,
  output logic              oEnAcc,
  input  logic [CWIDTH-1:0] iMacResult,
  output logic              oOutValid,
  output logic [CWIDTH-1:0] oOutData,
  input  logic              iOutReady,
  output logic              oBusy,
  output logic [15:0]       oSampleCnt
);
  state_t            state_q;
  logic [CWIDTH-1:0] coef_q [TAPS];
  logic [CWIDTH-1:0] out_q;
  logic [15:0]       cnt_q;
  logic              err_q, idle, accept, coef_ok;
  assign idle     = state_q == IDLE;
  assign oInReady = idle && iEnable;
  assign accept   = oInReady && iInValid;
  assign coef_ok  = idle && (iCoeffAddr < 4'(TAPS));
  fir_delay_line u_dly (
    .iClk   (iClk),
    .iRsn   (iRsn),
    .iShift (accept),
    .iFlush (iFlush && idle),
    .iData  (iInData),
    .oDelay (oDelay)
  );
  always_ff @(posedge iClk or negedge iRsn)
    if (!iRsn) begin
      state_q <= IDLE;
      out_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < TAPS; i++) coef_q[i] <= '0;
    end else begin
      err_q <= iCoeffWe && !coef_ok;
      if (iCoeffWe && coef_ok) coef_q[iCoeffAddr] <= iCoeffData;
      case (state_q)
        IDLE: if (accept) state_q <= MUL;
        MUL:  state_q <= ADD;
        ADD:  state_q <= ACC;
        ACC: begin
          out_q   <= iMacResult;
          state_q <= OUT;
        end
        OUT: if (iOutReady) begin
          cnt_q   <= cnt_q + 16'd1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  for (genvar j = 0; j < TAPS; j++) begin : g_coef
    assign oCoeff[coef_hi(j) -: CWIDTH] = coef_q[j];
  end
  assign oEnMul     = state_q == MUL || state_q == ADD || state_q == ACC;
  assign oEnAdd     = state_q == ADD || state_q == ACC;
  assign oEnAcc     = state_q == ACC;
  assign oOutValid  = state_q == OUT;
  assign oBusy      = !idle;
  assign oCoeffErr  = err_q;
  assign oOutData   = out_q;
  assign oSampleCnt = cnt_q;
endmodule

// File: tb/tb_fir_mac_ctrl.sv
// tb_fir_mac_ctrl: directed vectors for fir_mac_ctrl against a behavioural MAC datapath
module tb_fir_mac_ctrl;
  import fir_pkg::*;
  logic              iClk, iRsn, iEnable, iInValid, oInReady, iFlush;
  logic [2:0]        iInData;
  logic              iCoeffWe, oCoeffErr;
  logic [3:0]        iCoeffAddr;
  logic [15:0]       iCoeffData, iMacResult, oOutData, oSampleCnt;
  logic [29:0]       oDelay;
  logic [159:0]      oCoeff;
  logic              oEnMul, oEnAdd, oEnAcc, oOutValid, iOutReady, oBusy;
  int                nchk, nbad, mac_acc;
  logic [29:0]       m_dly;
  logic [159:0]      m_coef;
  logic [15:0]       m_cnt;
  typedef struct {
    logic [2:0]  smp;
    logic        fl;
    logic [15:0] exp;
  } vec_t;
  vec_t vt[12];

  fir_mac_ctrl dut (
    .iClk(iClk), .iRsn(iRsn), .iEnable(iEnable), .iInValid(iInValid), .iInData(iInData),
    .oInReady(oInReady), .iFlush(iFlush), .iCoeffWe(iCoeffWe), .iCoeffAddr(iCoeffAddr),
    .iCoeffData(iCoeffData), .oCoeffErr(oCoeffErr), .oDelay(oDelay), .oCoeff(oCoeff),
    .oEnMul(oEnMul), .oEnAdd(oEnAdd), .oEnAcc(oEnAcc), .iMacResult(iMacResult),
    .oOutValid(oOutValid), .oOutData(oOutData), .iOutReady(iOutReady), .oBusy(oBusy),
    .oSampleCnt(oSampleCnt)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  // stand-in for the MAC datapath: signed dot product truncated to 16 bits
  always_comb begin
    mac_acc = 0;
    for (int j = 0; j < TAPS; j++)
      mac_acc += int'($signed(oDelay[dly_hi(j) -: DWIDTH])) * int'($signed(oCoeff[coef_hi(j) -: CWIDTH]));
    iMacResult = mac_acc[15:0];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    nchk++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d, input logic bad);
    iCoeffWe = 1'b1; iCoeffAddr = a; iCoeffData = d;
    @(negedge iClk);
    iCoeffWe = 1'b0;
    if (!bad) m_coef[coef_hi(int'(a)) -: 16] = d;
    chk("coef_err", oCoeffErr, bad);
    chk("coef_bank", oCoeff, m_coef);
  endtask

  task automatic run_tx(input logic [2:0] smp, input logic fl, input logic [15:0] exp);
    chk("in_ready", oInReady, 1'b1);
    iInValid = 1'b1; iInData = smp; iFlush = fl;
    @(negedge iClk);
    iInValid = 1'b0; iFlush = 1'b0;
    m_dly = fl ? {smp, 27'b0} : {smp, m_dly[29:3]};
    chk("delay", oDelay, m_dly);
    chk("en_mul", {oEnMul, oEnAdd, oEnAcc}, 3'b100);
    @(negedge iClk);
    chk("en_add", {oEnMul, oEnAdd, oEnAcc}, 3'b110);
    @(negedge iClk);
    chk("en_acc", {oEnMul, oEnAdd, oEnAcc}, 3'b111);
    chk("valid_early", oOutValid, 1'b0);
    @(negedge iClk);
    chk("out_valid", oOutValid, 1'b1);
    chk("out_data", oOutData, exp);
    chk("en_out", {oEnMul, oEnAdd, oEnAcc}, 3'b000);
    @(negedge iClk);
    m_cnt = m_cnt + 16'd1;
    chk("idle_busy", oBusy, 1'b0);
    chk("sample_cnt", oSampleCnt, m_cnt);
  endtask

  task automatic chk_reset_vals();
    chk("rst_busy", oBusy, 1'b0);
    chk("rst_en", {oEnMul, oEnAdd, oEnAcc}, 3'b000);
    chk("rst_valid", oOutValid, 1'b0);
    chk("rst_err", oCoeffErr, 1'b0);
    chk("rst_delay", oDelay, 30'd0);
    chk("rst_coeff", oCoeff, 160'd0);
    chk("rst_data", oOutData, 16'd0);
    chk("rst_cnt", oSampleCnt, 16'd0);
  endtask

  initial begin
    nchk = 0; nbad = 0;
    m_dly = '0; m_coef = '0; m_cnt = '0;
    iRsn = 1'b0; iEnable = 1'b1; iInValid = 1'b0; iInData = '0; iFlush = 1'b0;
    iCoeffWe = 1'b0; iCoeffAddr = '0; iCoeffData = '0; iOutReady = 1'b1;
    vt[0] = '{3'b111, 1'b0, 16'hFFFE};
    for (int i = 1; i < 11; i++) vt[i] = '{3'b011, 1'b0, 16'h0006};
    vt[11] = '{3'b010, 1'b1, 16'h0004};
    repeat (2) @(negedge iClk);
    chk_reset_vals();
    iRsn = 1'b1;
    @(negedge iClk);
    // ramp: unit coefficients, single sample
    for (int i = 0; i < TAPS; i++) wr(4'(i), 16'h0001, 1'b0);
    chk("coef_ones", oCoeff, {10{16'h0001}});
    run_tx(3'b001, 1'b0, 16'h0001);
    // sign handling, preload and flush-with-accept
    wr(4'd0, 16'h0002, 1'b0);
    for (int i = 1; i < TAPS; i++) wr(4'(i), 16'h0000, 1'b0);
    for (int i = 0; i < 12; i++) begin
      if (i == 11) chk("preload", oDelay, {10{3'b011}});
      run_tx(vt[i].smp, vt[i].fl, vt[i].exp);
    end
    chk("flush_accept", oDelay, 30'h10000000);
    iFlush = 1'b1;
    @(negedge iClk);
    iFlush = 1'b0;
    m_dly = '0;
    chk("flush_only", oDelay, 30'd0);
    // backpressure in OUT
    iOutReady = 1'b0;
    iInValid = 1'b1; iInData = 3'b001;
    @(negedge iClk);
    iInValid = 1'b0;
    m_dly = {3'b001, m_dly[29:3]};
    repeat (3) @(negedge iClk);
    for (int k = 0; k < 3; k++) begin
      chk("bp_valid", oOutValid, 1'b1);
      chk("bp_data", oOutData, 16'h0002);
      chk("bp_ready", oInReady, 1'b0);
      iInValid = 1'b1; iInData = 3'b111;
      @(negedge iClk);
    end
    chk("bp_hold", oOutValid, 1'b1);
    iOutReady = 1'b1; iInValid = 1'b0;
    @(negedge iClk);
    m_cnt = m_cnt + 16'd1;
    chk("bp_release", oBusy, 1'b0);
    chk("bp_cnt", oSampleCnt, m_cnt);
    chk("bp_delay", oDelay, m_dly);
    // coefficient write rejected while busy
    iInValid = 1'b1; iInData = 3'b000;
    @(negedge iClk);
    iInValid = 1'b0;
    m_dly = {3'b000, m_dly[29:3]};
    chk("mul_state", {oEnMul, oEnAdd, oEnAcc}, 3'b100);
    iCoeffWe = 1'b1; iCoeffAddr = 4'd1; iCoeffData = 16'hBEEF;
    @(negedge iClk);
    iCoeffWe = 1'b0;
    chk("busy_wr_err", oCoeffErr, 1'b1);
    chk("busy_wr_bank", oCoeff, m_coef);
    @(negedge iClk);
    chk("busy_err_pulse", oCoeffErr, 1'b0);
    @(negedge iClk);
    chk("busy_wr_data", oOutData, 16'h0000);
    @(negedge iClk);
    m_cnt = m_cnt + 16'd1;
    chk("busy_wr_cnt", oSampleCnt, m_cnt);
    wr(4'd12, 16'h5555, 1'b1);
    @(negedge iClk);
    chk("addr_err_pulse", oCoeffErr, 1'b0);
    wr(4'd9, 16'h1234, 1'b0);
    chk("tap9_coef", oCoeff[15:0], 16'h1234);
    // enable low blocks acceptance
    iEnable = 1'b0;
    #1;
    chk("en_low_ready", oInReady, 1'b0);
    iInValid = 1'b1;
    repeat (2) @(negedge iClk);
    chk("en_low_busy", oBusy, 1'b0);
    chk("en_low_delay", oDelay, m_dly);
    iInValid = 1'b0; iEnable = 1'b1;
    // reset while in ACC
    iInValid = 1'b1; iInData = 3'b001;
    @(negedge iClk);
    iInValid = 1'b0;
    repeat (2) @(negedge iClk);
    chk("pre_rst_acc", {oEnMul, oEnAdd, oEnAcc}, 3'b111);
    iRsn = 1'b0;
    #1;
    chk_reset_vals();
    @(negedge iClk);
    iRsn = 1'b1;
    m_dly = '0; m_coef = '0; m_cnt = '0;
    for (int k = 0; k < 4; k++) begin
      @(negedge iClk);
      chk("post_rst_valid", oOutValid, 1'b0);
    end
    // counter wrap
    force dut.cnt_q = 16'hFFFF;
    #1;
    release dut.cnt_q;
    #1;
    m_cnt = 16'hFFFF;
    chk("cnt_preset", oSampleCnt, 16'hFFFF);
    run_tx(3'b001, 1'b0, 16'h0000);
    chk("cnt_wrap", oSampleCnt, 16'h0000);
    $display("test done: total=%0d bad=%0d", nchk, nbad);
    $finish;
  end
endmodule
